// File: rtl/spi_bus_arbiter_pkg.sv
// Shared types and helpers for the SPI bus arbiter: FSM state encoding,
// requester limits and the round-robin selection function.
package spi_bus_arbiter_pkg;

    localparam int N_MAX = 8;
    localparam int PTR_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        GRANTED,
        DRAIN
    } state_t;

    // Requests above the real requester count must be zero, so wrapping the
    // search at N_MAX-1 gives the same answer as wrapping at N-1.
    function automatic logic [N_MAX-1:0] rr_pick(input logic [N_MAX-1:0] req,
                                                 input logic [PTR_W-1:0] ptr);
        logic [N_MAX-1:0] grant;
        logic [PTR_W-1:0] idx;
        grant = '0;
        for (int i = N_MAX - 1; i >= 0; i--) begin
            idx = ptr + PTR_W'(i);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant of the first request at or
// after ptr, searching upward with wrap-around.
module rr_priority_pick
    import spi_bus_arbiter_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    assign grant = N'(rr_pick(N_MAX'(req), ptr));

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI master between N requesters.
// Optional inactivity watchdog compiled in with SPI_BUS_ARBITER_TIMEOUT_EN.
module spi_bus_arbiter
    import spi_bus_arbiter_pkg::*;
#(
    parameter int N         = 2,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 Clk_i,
    input  logic                 Reset_i,
    input  logic [N-1:0]         Req_i,
    output logic [N-1:0]         Grant_o,
    input  logic [N-1:0]         Write_i,
    input  logic [N-1:0]         ReadNext_i,
    input  logic [8*N-1:0]       Data_i,
    input  logic [N-1:0]         CS_n_i,
    input  logic [N-1:0]         CPOL_i,
    input  logic [N-1:0]         CPHA_i,
    input  logic [N-1:0]         LSBFE_i,
    input  logic                 SPI_Transmission_i,
    input  logic                 SPI_FIFOEmpty_i,
    input  logic                 SPI_FIFOFull_i,
    output logic                 SPI_Write_o,
    output logic                 SPI_ReadNext_o,
    output logic [7:0]           SPI_Data_o,
    output logic                 SPI_CPOL_o,
    output logic                 SPI_CPHA_o,
    output logic                 SPI_LSBFE_o,
    output logic [N-1:0]         CS_n_o,
    output logic                 Busy_o,
    output logic                 Timeout_o,
    input  logic [TIMEOUT_W-1:0] TimeoutPreset_i
);

    state_t           state_q, state_d;
    logic [N-1:0]     owner_q, owner_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             cs_last_q;
    logic             busy_q;
    logic [N-1:0]     eligible;
    logic [N-1:0]     pick;
    logic             wd_fire;

    // Selected requester's signals; owner_q is one-hot or zero.
    logic       sel_req, sel_write, sel_rn, sel_cs;
    logic [7:0] sel_data;

    assign sel_req   = |(Req_i & owner_q);
    assign sel_write = |(Write_i & owner_q);
    assign sel_rn    = |(ReadNext_i & owner_q);
    assign sel_cs    = |(CS_n_i & owner_q);

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (owner_q[k]) sel_data = Data_i[8*k +: 8];
        end
    end

`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wd_cnt_q;
    logic [N-1:0]         blocked_q;
    logic                 timeout_q;
    logic                 wd_idle;

    assign wd_idle  = !sel_write && !sel_rn && !SPI_Transmission_i;
    assign wd_fire  = (state_q == GRANTED) && sel_req && wd_idle &&
                      (TimeoutPreset_i != '0) &&
                      (wd_cnt_q == TimeoutPreset_i - TIMEOUT_W'(1));
    assign eligible = Req_i & ~blocked_q;
    assign Timeout_o = timeout_q;

    // A blocked requester is released once its request is sampled low.
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            wd_cnt_q  <= '0;
            blocked_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= wd_fire;
            blocked_q <= (blocked_q & Req_i) | (wd_fire ? owner_q : '0);
            if ((state_q == GRANTED) && wd_idle && !wd_fire)
                wd_cnt_q <= wd_cnt_q + TIMEOUT_W'(1);
            else
                wd_cnt_q <= '0;
        end
    end
`else
    logic unused_preset;

    assign unused_preset = ^TimeoutPreset_i;
    assign wd_fire       = 1'b0;
    assign eligible      = Req_i;
    assign Timeout_o     = 1'b0;
`endif

    rr_priority_pick #(.N(N)) u_pick (
        .req   (eligible),
        .ptr   (ptr_q),
        .grant (pick)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (|pick) begin
                    state_d = GRANTED;
                    owner_d = pick;
                    for (int k = 0; k < N; k++) begin
                        if (pick[k]) ptr_d = (k == N - 1) ? '0 : PTR_W'(k + 1);
                    end
                end
            end
            GRANTED: begin
                if (!sel_req || wd_fire) state_d = DRAIN;
            end
            DRAIN: begin
                if (!SPI_Transmission_i && SPI_FIFOEmpty_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            cs_last_q <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            busy_q  <= (state_d != IDLE);
            if (state_q == GRANTED) cs_last_q <= sel_cs;
        end
    end

    // Output muxing gated by the registered state and owner.
    always_comb begin
        Grant_o        = '0;
        SPI_Write_o    = 1'b0;
        SPI_ReadNext_o = 1'b0;
        SPI_Data_o     = '0;
        CS_n_o         = '1;
        SPI_CPOL_o     = 1'b0;
        SPI_CPHA_o     = 1'b0;
        SPI_LSBFE_o    = 1'b0;
        if (state_q != IDLE) begin
            SPI_CPOL_o  = |(CPOL_i & owner_q);
            SPI_CPHA_o  = |(CPHA_i & owner_q);
            SPI_LSBFE_o = |(LSBFE_i & owner_q);
        end
        if (state_q == GRANTED) begin
            Grant_o        = owner_q;
            SPI_Write_o    = sel_write && !SPI_FIFOFull_i;
            SPI_ReadNext_o = sel_rn;
            SPI_Data_o     = sel_data;
            CS_n_o         = CS_n_i | ~owner_q;
        end else if (state_q == DRAIN) begin
            CS_n_o = ~owner_q | {N{cs_last_q}};
        end
    end

    assign Busy_o = busy_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter with three requesters: the stimulus
// queues the expected outputs for each cycle, the monitor compares them.
module tb_spi_bus_arbiter;

    localparam int N  = 3;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req, grant, wr, rn, cs_in, cpol, cpha, lsbfe, cs_out;
    logic [8*N-1:0] data;
    logic          trans, fempty, ffull;
    logic          spi_wr, spi_rn, spi_cpol, spi_cpha, spi_lsbfe, busy, tmo;
    logic [7:0]    spi_data;
    logic [TW-1:0] preset;

    typedef struct {
        string       nm;
        logic [20:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    spi_bus_arbiter #(.N(N), .TIMEOUT_W(TW)) dut (
        .Clk_i              (clk),
        .Reset_i            (rst),
        .Req_i              (req),
        .Grant_o            (grant),
        .Write_i            (wr),
        .ReadNext_i         (rn),
        .Data_i             (data),
        .CS_n_i             (cs_in),
        .CPOL_i             (cpol),
        .CPHA_i             (cpha),
        .LSBFE_i            (lsbfe),
        .SPI_Transmission_i (trans),
        .SPI_FIFOEmpty_i    (fempty),
        .SPI_FIFOFull_i     (ffull),
        .SPI_Write_o        (spi_wr),
        .SPI_ReadNext_o     (spi_rn),
        .SPI_Data_o         (spi_data),
        .SPI_CPOL_o         (spi_cpol),
        .SPI_CPHA_o         (spi_cpha),
        .SPI_LSBFE_o        (spi_lsbfe),
        .CS_n_o             (cs_out),
        .Busy_o             (busy),
        .Timeout_o          (tmo),
        .TimeoutPreset_i    (preset)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string nm, input logic [2:0] g, input logic [2:0] cs,
                             input logic b, input logic t);
        n_checks++;
        if (grant !== g || cs_out !== cs || busy !== b || tmo !== t) begin
            n_fail++;
            $display("FAIL %s: got grant=%b cs_n=%b busy=%b tmo=%b, expected grant=%b cs_n=%b busy=%b tmo=%b",
                     nm, grant, cs_out, busy, tmo, g, cs, b, t);
        end
    endtask

    // Mode argument is {CPOL, CPHA, LSBFE} of the selected requester.
    task automatic expect_o(input string nm, input logic [2:0] g, input logic [2:0] cs,
                            input logic w, input logic r, input logic [7:0] d,
                            input logic b, input logic t, input logic [2:0] mode);
        exp_t e;
        e.nm = nm;
        e.v  = {g, cs, w, r, d, b, t, mode};
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [20:0] got;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {grant, cs_out, spi_wr, spi_rn, spi_data, busy, tmo,
                   spi_cpol, spi_cpha, spi_lsbfe};
            n_checks++;
            if (got !== e.v) begin
                n_fail++;
                $display("FAIL %s: got grant=%b cs_n=%b wr=%b rn=%b data=%h busy=%b tmo=%b mode=%b, expected grant=%b cs_n=%b wr=%b rn=%b data=%h busy=%b tmo=%b mode=%b",
                         e.nm, got[20:18], got[17:15], got[14], got[13], got[12:5], got[4], got[3], got[2:0],
                         e.v[20:18], e.v[17:15], e.v[14], e.v[13], e.v[12:5], e.v[4], e.v[3], e.v[2:0]);
            end
        end
    end

    // Requester modes: r0 = 3'b110, r1 = 3'b011, r2 = 3'b101.
    initial begin
        rst    = 1'b1;
        req    = '0;
        wr     = '0;
        rn     = '0;
        data   = {8'h33, 8'hA5, 8'h5A};
        cs_in  = '1;
        cpol   = 3'b101;
        cpha   = 3'b011;
        lsbfe  = 3'b110;
        trans  = 1'b0;
        fempty = 1'b1;
        ffull  = 1'b0;
        preset = '0;

        tick();
        tick();
        check_now("reset_state_direct", 3'b000, 3'b111, 0, 0);
        expect_o("reset_state", 3'b000, 3'b111, 0, 0, 8'h00, 0, 0, 3'b000);

        // Simultaneous requests 1 and 2 with Ptr=0
        tick();
        rst = 1'b0;
        req = 3'b110;
        expect_o("idle_before_grant", 3'b000, 3'b111, 0, 0, 8'h00, 0, 0, 3'b000);
        tick();
        cs_in = 3'b101;
        wr    = 3'b010;
        expect_o("gnt1_write", 3'b010, 3'b101, 1, 0, 8'hA5, 1, 0, 3'b011);
        tick();
        wr = '0;
        rn = 3'b010;
        expect_o("gnt1_readnext", 3'b010, 3'b101, 0, 1, 8'hA5, 1, 0, 3'b011);
        tick();
        rn  = '0;
        req = 3'b100;
        expect_o("gnt1_release_cycle", 3'b010, 3'b101, 0, 0, 8'hA5, 1, 0, 3'b011);
        tick();
        cs_in = 3'b111;
        expect_o("drain1_cs_hold", 3'b000, 3'b101, 0, 0, 8'h00, 1, 0, 3'b011);
        tick();
        expect_o("idle_gap", 3'b000, 3'b111, 0, 0, 8'h00, 0, 0, 3'b000);
        tick();
        cs_in = 3'b011;
        expect_o("gnt2_round_robin", 3'b100, 3'b011, 0, 0, 8'h33, 1, 0, 3'b101);
        tick();
        req = '0;
        expect_o("gnt2_release_cycle", 3'b100, 3'b011, 0, 0, 8'h33, 1, 0, 3'b101);
        tick();
        cs_in = 3'b111;
        expect_o("drain2_cs_hold", 3'b000, 3'b011, 0, 0, 8'h00, 1, 0, 3'b101);
        tick();
        req = 3'b001;
        expect_o("idle_gap2", 3'b000, 3'b111, 0, 0, 8'h00, 0, 0, 3'b000);
        tick();
        expect_o("gnt0_alone", 3'b001, 3'b111, 0, 0, 8'h5A, 1, 0, 3'b110);

        // Isolation of a non-granted requester
        tick();
        wr    = 3'b010;
        cs_in = 3'b100;
        expect_o("isolation", 3'b001, 3'b110, 0, 0, 8'h5A, 1, 0, 3'b110);

        // FIFO full masks the write strobe
        tick();
        wr    = 3'b001;
        ffull = 1'b1;
        cs_in = 3'b111;
        expect_o("fifo_full_1", 3'b001, 3'b111, 0, 0, 8'h5A, 1, 0, 3'b110);
        tick();
        expect_o("fifo_full_2", 3'b001, 3'b111, 0, 0, 8'h5A, 1, 0, 3'b110);
        tick();
        expect_o("fifo_full_3", 3'b001, 3'b111, 0, 0, 8'h5A, 1, 0, 3'b110);
        tick();
        ffull = 1'b0;
        expect_o("fifo_free", 3'b001, 3'b111, 1, 0, 8'h5A, 1, 0, 3'b110);

        // Drain held by an active transmission while requester 1 waits
        tick();
        wr     = '0;
        req    = 3'b010;
        trans  = 1'b1;
        fempty = 1'b0;
        cs_in  = 3'b110;
        expect_o("gnt0_release_cycle", 3'b001, 3'b110, 0, 0, 8'h5A, 1, 0, 3'b110);
        tick();
        cs_in = 3'b111;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            expect_o("drain_hold", 3'b000, 3'b110, 0, 0, 8'h00, 1, 0, 3'b110);
        end
        tick();
        trans  = 1'b0;
        fempty = 1'b1;
        expect_o("drain_last", 3'b000, 3'b110, 0, 0, 8'h00, 1, 0, 3'b110);
        tick();
        expect_o("idle_after_drain", 3'b000, 3'b111, 0, 0, 8'h00, 0, 0, 3'b000);
        tick();
        expect_o("gnt1_after_drain", 3'b010, 3'b111, 0, 0, 8'hA5, 1, 0, 3'b011);

        // Reset in the middle of a transaction
        tick();
        cs_in = 3'b101;
        rst   = 1'b1;
        expect_o("pre_reset", 3'b010, 3'b101, 0, 0, 8'hA5, 1, 0, 3'b011);
        tick();
        check_now("reset_mid_txn_direct", 3'b000, 3'b111, 0, 0);
        rst = 1'b0;
        req = 3'b111;
        expect_o("reset_mid_txn", 3'b000, 3'b111, 0, 0, 8'h00, 0, 0, 3'b000);
        tick();
        expect_o("ptr_after_reset", 3'b001, 3'b111, 0, 0, 8'h5A, 1, 0, 3'b110);
        tick();
        req   = '0;
        cs_in = 3'b111;
        expect_o("gnt0_release_again", 3'b001, 3'b111, 0, 0, 8'h5A, 1, 0, 3'b110);
        tick();
        tick();
        preset = TW'(10);
        req    = 3'b001;
        expect_o("wd_idle", 3'b000, 3'b111, 0, 0, 8'h00, 0, 0, 3'b000);
        tick();
        expect_o("wd_granted", 3'b001, 3'b111, 0, 0, 8'h5A, 1, 0, 3'b110);
        for (int i = 0; i < 9; i++) tick();
        expect_o("wd_tenth_idle_cycle", 3'b001, 3'b111, 0, 0, 8'h5A, 1, 0, 3'b110);
        tick();
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
        check_now("wd_expired_direct", 3'b000, 3'b111, 1, 1);
        expect_o("wd_timeout_pulse", 3'b000, 3'b111, 0, 0, 8'h00, 1, 1, 3'b110);
        tick();
        expect_o("wd_pulse_ends", 3'b000, 3'b111, 0, 0, 8'h00, 0, 0, 3'b000);
        tick();
        expect_o("wd_blocked", 3'b000, 3'b111, 0, 0, 8'h00, 0, 0, 3'b000);
        tick();
        req = '0;
        expect_o("wd_blocked_2", 3'b000, 3'b111, 0, 0, 8'h00, 0, 0, 3'b000);
        tick();
        req = 3'b001;
        expect_o("wd_unblock", 3'b000, 3'b111, 0, 0, 8'h00, 0, 0, 3'b000);
        tick();
        expect_o("wd_regrant", 3'b001, 3'b111, 0, 0, 8'h5A, 1, 0, 3'b110);
`else
        check_now("no_wd_direct", 3'b001, 3'b111, 1, 0);
        expect_o("no_wd_still_granted", 3'b001, 3'b111, 0, 0, 8'h5A, 1, 0, 3'b110);
        tick();
        expect_o("no_wd_still_granted_2", 3'b001, 3'b111, 0, 0, 8'h5A, 1, 0, 3'b110);
`endif
        tick();
        req = '0;
        tick();
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
